// File: rtl/emu_pkg.sv
// Shared definitions for the co-emulation transactor: FSM state codes,
// host register map helpers and status bit positions.
package emu_pkg;

    typedef logic [2:0] emu_state_t;

    localparam emu_state_t ST_IDLE    = 3'd0;
    localparam emu_state_t ST_LOAD    = 3'd1;
    localparam emu_state_t ST_RUN     = 3'd2;
    localparam emu_state_t ST_CAPTURE = 3'd3;
    localparam emu_state_t ST_DONE    = 3'd4;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;

    // Control registers sit at the top of the address space so the
    // stimulus/capture slices can grow from address 0 upwards.
    function automatic int unsigned stat_addr(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    function automatic int unsigned cyc_addr(input int unsigned aw);
        return (32'd1 << aw) - 32'd2;
    endfunction

endpackage

// File: rtl/emu_host_if.sv
// Host-side register bus plus start/status handshake of the transactor.
interface emu_host_if #(
    parameter int ADDR_W = 8,
    parameter int BUS_W  = 8
);
    logic [ADDR_W-1:0] host_addr;
    logic [BUS_W-1:0]  host_wdata;
    logic              host_we;
    logic [BUS_W-1:0]  host_rdata;
    logic              cmd_start;
    logic              busy;
    logic              done;

    modport master (
        output host_addr, host_wdata, host_we, cmd_start,
        input  host_rdata, busy, done
    );

    modport slave (
        input  host_addr, host_wdata, host_we, cmd_start,
        output host_rdata, busy, done
    );
endinterface

// File: rtl/emu_regbank.sv
// Stimulus shadow/applied banks, capture bank and registered host read mux.
module emu_regbank
    import emu_pkg::*;
#(
    parameter int BUS_W  = 8,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [BUS_W-1:0]       host_wdata,
    input  logic                   host_we,
    input  logic                   load,
    input  logic                   capture,
    input  logic                   busy,
    input  logic                   done,
    input  logic [N_OUT*BUS_W-1:0] dut_out,
    output logic [N_IN*BUS_W-1:0]  dut_in,
    output logic [BUS_W-1:0]       host_rdata
);

    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(stat_addr(ADDR_W));

    logic [BUS_W-1:0] shadow [N_IN];
    logic [BUS_W-1:0] cap    [N_OUT];
    logic [BUS_W-1:0] rdata_nxt;

    // Slice 0 maps to the most significant slice of the flat DUT vectors.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) shadow[i] <= '0;
            for (int i = 0; i < N_OUT; i++) cap[i] <= '0;
            dut_in     <= '0;
            host_rdata <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (host_we && host_addr == ADDR_W'(i)) shadow[i] <= host_wdata;
            end
            if (load) begin
                for (int i = 0; i < N_IN; i++) dut_in[(N_IN-1-i)*BUS_W +: BUS_W] <= shadow[i];
            end
            if (capture) begin
                for (int i = 0; i < N_OUT; i++) cap[i] <= dut_out[(N_OUT-1-i)*BUS_W +: BUS_W];
            end
            host_rdata <= rdata_nxt;
        end
    end

    always_comb begin
        rdata_nxt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (host_addr == ADDR_W'(i)) rdata_nxt = cap[i];
        end
        if (host_addr == STAT_A) begin
            rdata_nxt[STAT_DONE_BIT] = done;
            rdata_nxt[STAT_BUSY_BIT] = busy;
        end
    end

endmodule

// File: rtl/emu_xactor.sv
// Co-emulation transactor: loads stimulus, runs the DUT for a programmed
// number of clock-enable cycles, captures its outputs and flags completion.
module emu_xactor
    import emu_pkg::*;
#(
    parameter int BUS_W  = 8,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int ADDR_W = 8,
    parameter int CYC_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    emu_host_if.slave              host,
    output logic [N_IN*BUS_W-1:0]  dut_in,
    input  logic [N_OUT*BUS_W-1:0] dut_out,
    output logic                   dut_ce,
    output logic                   led
);

    localparam logic [ADDR_W-1:0] CYC_A = ADDR_W'(cyc_addr(ADDR_W));

    emu_state_t       state, state_nxt;
    logic [CYC_W-1:0] run_cnt;
    logic [CYC_W-1:0] cyc_left;
    logic             done_q;
    logic [3:0]       led_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (host.cmd_start) state_nxt = ST_LOAD;
            ST_LOAD:          state_nxt = (run_cnt != '0) ? ST_RUN : ST_CAPTURE;
            ST_RUN:           if (cyc_left == CYC_W'(1)) state_nxt = ST_CAPTURE;
            ST_CAPTURE:       state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // dut_ce is a flop driven from the next state so the DUT sees a clean enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            run_cnt  <= CYC_W'(1);
            cyc_left <= '0;
            done_q   <= 1'b0;
            dut_ce   <= 1'b0;
            led_cnt  <= '0;
        end else begin
            state  <= state_nxt;
            dut_ce <= (state_nxt == ST_RUN);
            if (host.host_we && host.host_addr == CYC_A) run_cnt <= CYC_W'(host.host_wdata);
            case (state)
                ST_LOAD: begin
                    cyc_left <= run_cnt;
                    done_q   <= 1'b0;
                end
                ST_RUN:     if (cyc_left != '0) cyc_left <= cyc_left - CYC_W'(1);
                ST_CAPTURE: done_q <= 1'b1;
                default:    ;
            endcase
            if (dut_ce) led_cnt <= led_cnt + 4'd1;
        end
    end

    assign host.busy = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_CAPTURE);
    assign host.done = done_q;
    assign led       = led_cnt[3];

    emu_regbank #(
        .BUS_W  (BUS_W),
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .ADDR_W (ADDR_W)
    ) u_regbank (
        .clk        (clk),
        .reset      (reset),
        .host_addr  (host.host_addr),
        .host_wdata (host.host_wdata),
        .host_we    (host.host_we),
        .load       (state == ST_LOAD),
        .capture    (state == ST_CAPTURE),
        .busy       (host.busy),
        .done       (done_q),
        .dut_out    (dut_out),
        .dut_in     (dut_in),
        .host_rdata (host.host_rdata)
    );

endmodule

// File: tb/tb_emu_xactor.sv
// Directed self-checking bench for emu_xactor: register access, run timing,
// zero-count runs, ignored starts, mid-run reset and the activity LED.
module tb_emu_xactor;

    localparam int BUS_W  = 8;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 3;
    localparam int ADDR_W = 8;
    localparam int CYC_W  = 8;
    localparam logic [7:0] CYC_ADDR  = 8'hFE;
    localparam logic [7:0] STAT_ADDR = 8'hFF;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_IN*BUS_W-1:0]  dut_in;
    logic [N_OUT*BUS_W-1:0] dut_out;
    logic                   dut_ce;
    logic                   led;

    int vectors     = 0;
    int miscompares = 0;

    emu_host_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) host ();

    emu_xactor #(
        .BUS_W(BUS_W), .N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W), .CYC_W(CYC_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .host    (host),
        .dut_in  (dut_in),
        .dut_out (dut_out),
        .dut_ce  (dut_ce),
        .led     (led)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        host.host_addr  = a;
        host.host_wdata = d;
        host.host_we    = 1'b1;
        tick();
        host.host_we    = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] d);
        host.host_addr = a;
        tick();
        d = host.host_rdata;
    endtask

    task automatic pulse_start();
        host.cmd_start = 1'b1;
        tick();
        host.cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        host_read(STAT_ADDR, rd);
        vectors++; if (rd !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_stat: got %h expected 00", rd); end
        vectors++; if (dut_in !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_dut_in: got %h expected 0", dut_in); end
        vectors++; if (dut_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dut_ce: got %b expected 0", dut_ce); end
        vectors++; if (led !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_led: got %b expected 0", led); end
        host_read(8'h00, rd);
        vectors++; if (rd !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_cap0: got %h expected 00", rd); end
    endtask

    task automatic test_main_run();
        logic [7:0] rd;
        host_write(8'h00, 8'h12);
        host_write(8'h01, 8'h34);
        host_write(8'h02, 8'h56);
        host_write(8'h03, 8'h78);
        host_write(CYC_ADDR, 8'd5);
        dut_out = 24'hABCDEF;
        host.host_addr = 8'h10;
        pulse_start();
        vectors++; if (host.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL main_load_busy: got %b expected 1", host.busy); end
        vectors++; if (dut_in !== 32'h0) begin miscompares++; $display("[TB] FAIL main_load_dut_in: got %h expected 0", dut_in); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            vectors++; if (dut_ce !== (i <= 5)) begin miscompares++; $display("[TB] FAIL main_ce c%0d: got %b expected %b", i, dut_ce, (i <= 5)); end
            vectors++; if (host.busy !== (i <= 6)) begin miscompares++; $display("[TB] FAIL main_busy c%0d: got %b expected %b", i, host.busy, (i <= 6)); end
            vectors++; if (host.done !== (i >= 7)) begin miscompares++; $display("[TB] FAIL main_done c%0d: got %b expected %b", i, host.done, (i >= 7)); end
            vectors++; if (dut_in !== 32'h12345678) begin miscompares++; $display("[TB] FAIL main_dut_in c%0d: got %h expected 12345678", i, dut_in); end
        end
        host_read(8'h00, rd);
        vectors++; if (rd !== 8'hAB) begin miscompares++; $display("[TB] FAIL main_cap0: got %h expected ab", rd); end
        host_read(8'h01, rd);
        vectors++; if (rd !== 8'hCD) begin miscompares++; $display("[TB] FAIL main_cap1: got %h expected cd", rd); end
        host_read(8'h02, rd);
        vectors++; if (rd !== 8'hEF) begin miscompares++; $display("[TB] FAIL main_cap2: got %h expected ef", rd); end
        host_read(8'h03, rd);
        vectors++; if (rd !== 8'h00) begin miscompares++; $display("[TB] FAIL main_unmapped_read: got %h expected 00", rd); end
        host_read(STAT_ADDR, rd);
        vectors++; if (rd !== 8'h02) begin miscompares++; $display("[TB] FAIL main_stat_done: got %h expected 02", rd); end
    endtask

    task automatic test_zero_count();
        logic [7:0] rd;
        host_write(CYC_ADDR, 8'd0);
        dut_out = 24'h010203;
        pulse_start();
        vectors++; if (host.done !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_load_done_held: got %b expected 1", host.done); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++; if (dut_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_ce c%0d: got %b expected 0", i, dut_ce); end
            vectors++; if (host.busy !== (i <= 1)) begin miscompares++; $display("[TB] FAIL zero_busy c%0d: got %b expected %b", i, host.busy, (i <= 1)); end
            vectors++; if (host.done !== (i >= 2)) begin miscompares++; $display("[TB] FAIL zero_done c%0d: got %b expected %b", i, host.done, (i >= 2)); end
        end
        host_read(8'h00, rd);
        vectors++; if (rd !== 8'h01) begin miscompares++; $display("[TB] FAIL zero_cap0: got %h expected 01", rd); end
        host_read(8'h01, rd);
        vectors++; if (rd !== 8'h02) begin miscompares++; $display("[TB] FAIL zero_cap1: got %h expected 02", rd); end
    endtask

    task automatic test_start_ignored();
        logic [7:0] exp_rd;
        host_write(CYC_ADDR, 8'd6);
        dut_out = 24'h5A0000;
        pulse_start();
        host.host_addr = 8'h00;
        for (int i = 1; i <= 9; i++) begin
            if (i == 2) begin
                host.cmd_start  = 1'b1;
                host.host_we    = 1'b1;
                host.host_wdata = 8'hFF;
            end else begin
                host.cmd_start = 1'b0;
                host.host_we   = 1'b0;
            end
            tick();
            exp_rd = (i >= 9) ? 8'h5A : 8'h01;
            vectors++; if (dut_ce !== (i <= 6)) begin miscompares++; $display("[TB] FAIL ign_ce c%0d: got %b expected %b", i, dut_ce, (i <= 6)); end
            vectors++; if (host.done !== (i >= 8)) begin miscompares++; $display("[TB] FAIL ign_done c%0d: got %b expected %b", i, host.done, (i >= 8)); end
            vectors++; if (dut_in !== 32'h12345678) begin miscompares++; $display("[TB] FAIL ign_dut_in c%0d: got %h expected 12345678", i, dut_in); end
            vectors++; if (host.host_rdata !== exp_rd) begin miscompares++; $display("[TB] FAIL ign_rdata c%0d: got %h expected %h", i, host.host_rdata, exp_rd); end
        end
        pulse_start();
        tick();
        vectors++; if (dut_in !== 32'hFF345678) begin miscompares++; $display("[TB] FAIL ign_new_stim: got %h expected ff345678", dut_in); end
        for (int i = 2; i <= 8; i++) tick();
        vectors++; if (host.done !== 1'b1) begin miscompares++; $display("[TB] FAIL ign_second_done: got %b expected 1", host.done); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] rd;
        host_write(CYC_ADDR, 8'd10);
        dut_out = 24'h777777;
        pulse_start();
        tick();
        tick();
        tick();
        vectors++; if (dut_ce !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_ce_before: got %b expected 1", dut_ce); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (dut_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ce_after: got %b expected 0", dut_ce); end
        vectors++; if (host.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b expected 0", host.busy); end
        vectors++; if (host.done !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_done: got %b expected 0", host.done); end
        vectors++; if (dut_in !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_dut_in: got %h expected 0", dut_in); end
        host_read(8'h00, rd);
        vectors++; if (rd !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_cap0: got %h expected 00", rd); end
        host_read(STAT_ADDR, rd);
        vectors++; if (rd !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_stat: got %h expected 00", rd); end
        // Run count returns to 1 after reset: one enable cycle, done 3 cycles later.
        pulse_start();
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++; if (dut_ce !== (i == 1)) begin miscompares++; $display("[TB] FAIL mid_default_ce c%0d: got %b expected %b", i, dut_ce, (i == 1)); end
            vectors++; if (host.done !== (i >= 3)) begin miscompares++; $display("[TB] FAIL mid_default_done c%0d: got %b expected %b", i, host.done, (i >= 3)); end
        end
    endtask

    task automatic test_led();
        logic [4:0] cnt;
        logic       exp_led;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        host_write(CYC_ADDR, 8'd16);
        pulse_start();
        for (int i = 1; i <= 18; i++) begin
            tick();
            cnt     = (i <= 16) ? 5'(i - 1) : 5'd16;
            exp_led = (cnt >= 5'd8) && (cnt < 5'd16);
            vectors++; if (led !== exp_led) begin miscompares++; $display("[TB] FAIL led c%0d: got %b expected %b", i, led, exp_led); end
        end
        vectors++; if (host.done !== 1'b1) begin miscompares++; $display("[TB] FAIL led_done: got %b expected 1", host.done); end
    endtask

    initial begin
        reset           = 1'b1;
        dut_out         = '0;
        host.host_addr  = '0;
        host.host_wdata = '0;
        host.host_we    = 1'b0;
        host.cmd_start  = 1'b0;
        test_reset();
        test_main_run();
        test_zero_count();
        test_start_ignored();
        test_reset_mid_run();
        test_led();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/emu_xactor.md
# emu_xactor

Parametrised co-emulation transactor for parallel-IO DUTs. Host-side byte-wide register bus loads double-buffered stimulus; on a start command the block applies it to the DUT, runs the DUT for a programmable number of clock-enable cycles, captures DUT outputs, and flags completion. It sits between the emulation host port and any DUT with flat input/output vectors, and replaces per-DUT hand-written wrappers.

## Interface

Parameters:
- BUS_W, 8, host data width and stimulus/capture slice width
- N_IN, 4, number of stimulus slices (1..ADDR space-2)
- N_OUT, 3, number of capture slices
- ADDR_W, 8, host address width
- CYC_W, 8, run-count register width

Ports:
- clk  in  1  single clock; DUT is clocked by clk and qualified by dut_ce
- reset  in  1  synchronous, active-high
- host_addr  in  ADDR_W  register address
- host_wdata  in  BUS_W  write data
- host_we  in  1  write strobe, one write per asserted cycle
- host_rdata  out  BUS_W  registered read data for host_addr
- cmd_start  in  1  start pulse
- busy  out  1  run in progress
- done  out  1  sticky completion flag
- dut_in  out  N_IN*BUS_W  applied stimulus
- dut_out  in  N_OUT*BUS_W  DUT result
- dut_ce  out  1  DUT clock enable
- led  out  1  activity indicator

## Operation

- Address map: writes to 0..N_IN-1 update stimulus shadow slice; write to CYC_ADDR = 2^ADDR_W-2 sets run count (low CYC_W bits); other writes ignored. Reads of 0..N_OUT-1 return capture slice; read of STAT_ADDR = 2^ADDR_W-1 returns {done, busy} in bits [1:0], zero-extended; other reads return 0.
- Slice order: slice 0 is MSB of dut_in / dut_out.
- FSM: IDLE -> LOAD on cmd_start; LOAD -> RUN if latched count > 0, else -> CAPTURE; RUN -> CAPTURE after count cycles; CAPTURE -> DONE; DONE -> LOAD on cmd_start.
- LOAD: copy shadow to dut_in, latch run count into down-counter, clear done.
- RUN: dut_ce = 1 every cycle, counter decrements.
- CAPTURE: sample dut_out into capture bank.
- DONE: done = 1, held until next accepted start.
- cmd_start in LOAD/RUN/CAPTURE ignored.
- Host writes during busy land in shadow/count register only; take effect at next LOAD. Reads during busy return previous capture.
- led = bit 3 of a 4-bit counter incremented on each dut_ce cycle.
- Reset values: host_rdata 0, busy 0, done 0, dut_in 0, dut_ce 0, led 0; shadow and capture banks 0; run count 1; FSM IDLE.
- Reset mid-run: next cycle FSM IDLE, dut_ce 0, all registers at reset values; no capture performed.

## Timing

- cmd_start sampled at edge t: LOAD in cycle t+1; dut_in valid from t+2.
- N = run count: dut_ce high in cycles t+2..t+1+N (registered, glitch-free).
- CAPTURE in cycle t+2+N; capture bank valid and done = 1 from t+3+N. Start-to-done latency N+3 (N=0: 3).
- busy high exactly in LOAD/RUN/CAPTURE cycles.
- host_rdata: address at edge k, data at cycle k+1. Read coinciding with capture edge returns pre-capture value.
- Write and read of same stimulus address same cycle: write takes effect, read unaffected (stimulus not readable).
- Run-count counter wraps never: loads latched count, stops at 0.

## Structure

- Package emu_pkg: FSM state enum (IDLE, LOAD, RUN, CAPTURE, DONE), CYC_ADDR/STAT_ADDR as functions of ADDR_W, status bit positions.
- Sub-module emu_regbank: shadow stimulus, applied stimulus, capture bank and host read mux; FSM and counters stay in emu_xactor.

## Test plan

- Reset, then read STAT_ADDR -> host_rdata 0x00; dut_in 0, dut_ce 0, led 0.
- Write stim {0x12,0x34,0x56,0x78}, count 5, pulse start -> dut_in 0x12345678 from t+2, dut_ce high 5 cycles, done at t+8; dut_out 0xABCDEF reads back 0xAB,0xCD,0xEF.
- Count 0, start -> no dut_ce, done 3 cycles after start; capture taken.
- Start during RUN ignored; stim write of 0xFF to slice 0 during RUN leaves dut_in unchanged, appears after next start.
- Reset asserted mid-RUN -> dut_ce 0 next cycle, busy 0, done 0, capture bank 0.
- 16 accumulated dut_ce cycles -> led toggles at dut_ce 8 and 16.
